// File: rtl/fp_accum_pkg.sv
// Shared definitions for the fp_accum slice: FSM state encoding, out_flag bit positions
// and exponent helpers for the {sign, expo, frac} packed format.
package fp_accum_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_SUB  = 1;
  localparam int FLAG_INF  = 2;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_expo_inf(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_accum_lzc.sv
// fp_lzc: combinational leading-zero counter; returns W when the input is all zeros.
module fp_lzc #(
  parameter int W  = 15,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_accum.sv
// Sequential FP accumulator: 4 cycles per term (ALIGN/ADD/NORM), sum held in OUT until out_ready.
// Overflow saturates to max finite when FP_ACC_SAT_EN is defined, otherwise produces inf.
module fp_accum
  import fp_accum_pkg::*;
#(
  parameter int EXP  = 5,
  parameter int FRA  = 10,
  parameter int GRD  = 3,
  parameter int CNTW = 8
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP+FRA:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP+FRA:0]     out_data,
  output logic [CNTW-1:0]      out_count,
  output logic [2:0]           out_flag
);

  localparam int W  = EXP + FRA + 1;
  localparam int MW = FRA + GRD + 2;
  localparam int EW = EXP + 2;
  localparam int LW = $clog2(MW + 1);
  localparam logic [EW-1:0] EXPO_INF = EW'(fp_expo_inf(EXP));
  localparam logic [MW-1:0] ONES     = '1;

  state_t            state, state_nxt;
  logic [W-1:0]      acc, term;
  logic              last, ovf;
  logic [CNTW-1:0]   count;
  logic [MW-1:0]     al_big, al_small, sum;
  logic              al_big_s, al_small_s, al_inf, al_inf_s, sum_s, sum_inf;
  logic [EW-1:0]     al_exp, sum_exp;

  function automatic logic [EW-1:0] eff_exp(input logic [W-1:0] x);
    return (x[W-2:FRA] == '0) ? EW'(1) : EW'(x[W-2:FRA]);
  endfunction

  function automatic logic [MW-1:0] mant(input logic [W-1:0] x);
    return {1'b0, x[W-2:FRA] != '0, x[FRA-1:0], {GRD{1'b0}}};
  endfunction

  // ALIGN: pick the larger-exponent operand, shift the other right with sticky LSB
  logic [EW-1:0] ea, et, diff, big_e, sh;
  logic [MW-1:0] big_m, sm, lost, sm_al;
  logic          big_s, sm_s, inf_n, inf_s_n;

  always_comb begin
    ea = eff_exp(acc);
    et = eff_exp(term);
    if (ea >= et) begin
      big_m = mant(acc);  big_s = acc[W-1];  sm = mant(term); sm_s = term[W-1];
      big_e = ea;         diff  = ea - et;
    end else begin
      big_m = mant(term); big_s = term[W-1]; sm = mant(acc);  sm_s = acc[W-1];
      big_e = et;         diff  = et - ea;
    end
    sh      = (diff > EW'(MW)) ? EW'(MW) : diff;
    lost    = sm & ~(ONES << sh);
    sm_al   = (sm >> sh) | MW'(|lost);
    inf_n   = (acc[W-2:FRA] == '1) || (term[W-2:FRA] == '1);
    inf_s_n = (acc[W-2:FRA] == '1) ? acc[W-1] : term[W-1];
  end

  logic [MW-1:0] sum_n;
  logic          sgn_n;

  always_comb begin
    if (al_big_s == al_small_s) begin
      sum_n = al_big + al_small;  sgn_n = al_big_s;
    end else if (al_big >= al_small) begin
      sum_n = al_big - al_small;  sgn_n = al_big_s;
    end else begin
      sum_n = al_small - al_big;  sgn_n = al_small_s;
    end
  end

  // NORM: put the leading one at the hidden-bit position, never below exponent 1
  logic [LW-1:0]  lz;
  logic [EW-1:0]  lsh, lim, ne, re;
  logic [MW-1:0]  nm;
  logic [FRA+1:0] r;
  logic [FRA:0]   rm;
  logic           n_ovf;
  logic [W-1:0]   res;

  fp_lzc #(.W(MW), .CW(LW)) u_lzc (.din(sum), .cnt(lz));

  always_comb begin
    lsh = EW'(lz) - EW'(1);
    lim = sum_exp - EW'(1);
    if (sum[MW-1]) begin
      nm = {1'b0, sum[MW-1:2], sum[1] | sum[0]};
      ne = sum_exp + EW'(1);
    end else begin
      if (lsh > lim) lsh = lim;
      nm = sum << lsh;
      ne = sum_exp - lsh;
    end
    r = {1'b0, nm[MW-2:GRD]} + (FRA+2)'(nm[GRD-1]);
    if (r[FRA+1]) begin
      rm = r[FRA+1:1];  re = ne + EW'(1);
    end else begin
      rm = r[FRA:0];    re = ne;
    end
    n_ovf = rm[FRA] && (re >= EXPO_INF);
    if (sum_inf)
      res = {sum_s, EXPO_INF[EXP-1:0], {FRA{1'b0}}};
    else if (n_ovf)
`ifdef FP_ACC_SAT_EN
      res = {sum_s, EXP'(EXPO_INF - EW'(1)), {FRA{1'b1}}};
`else
      res = {sum_s, EXPO_INF[EXP-1:0], {FRA{1'b0}}};
`endif
    else if (rm == '0)
      res = '0;
    else
      res = {sum_s, rm[FRA] ? re[EXP-1:0] : {EXP{1'b0}}, rm[FRA-1:0]};
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !aresetn;
        if (in_valid && in_ready) state_nxt = ALIGN;
      end
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = last ? OUT : IDLE;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (aresetn) begin
      state      <= IDLE;
      acc        <= '0;
      term       <= '0;
      last       <= 1'b0;
      count      <= '0;
      ovf        <= 1'b0;
      al_big     <= '0;
      al_small   <= '0;
      al_big_s   <= 1'b0;
      al_small_s <= 1'b0;
      al_exp     <= '0;
      al_inf     <= 1'b0;
      al_inf_s   <= 1'b0;
      sum        <= '0;
      sum_s      <= 1'b0;
      sum_exp    <= '0;
      sum_inf    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid && in_ready) begin
          term <= in_data;
          last <= in_last;
          if (count != '1) count <= count + CNTW'(1);
        end
        ALIGN: begin
          al_big     <= big_m;
          al_small   <= sm_al;
          al_big_s   <= big_s;
          al_small_s <= sm_s;
          al_exp     <= big_e;
          al_inf     <= inf_n;
          al_inf_s   <= inf_s_n;
        end
        ADD: begin
          sum     <= sum_n;
          sum_s   <= al_inf ? al_inf_s : sgn_n;
          sum_exp <= al_exp;
          sum_inf <= al_inf;
        end
        NORM: begin
          acc <= res;
          ovf <= ovf | (n_ovf & ~sum_inf);
        end
        OUT: if (out_ready) begin
          acc   <= '0;
          count <= '0;
          ovf   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_data            = out_valid ? acc : '0;
    out_count           = out_valid ? count : '0;
    out_flag            = '0;
    out_flag[FLAG_ZERO] = out_valid && (acc[W-2:0] == '0);
    out_flag[FLAG_SUB]  = out_valid && (acc[W-2:FRA] == '0) && (acc[FRA-1:0] != '0);
    out_flag[FLAG_INF]  = out_valid && ((acc[W-2:FRA] == '1) || ovf);
  end

endmodule

// File: tb/tb_fp_accum.sv
// Directed bench for fp_accum (EXP=5, FRA=10): hand-computed half-precision sums checked with assertions.
module tb_fp_accum;

  logic        clk = 1'b0;
  logic        aresetn = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [7:0]  out_count;
  logic [2:0]  out_flag;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_accum #(.EXP(5), .FRA(10), .GRD(3), .CNTW(8)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_flag  (out_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting rising edge.
  task automatic send(input logic [15:0] d, input logic l);
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] d, input logic [7:0] c,
                            input logic [2:0] f);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(d));
    check({tag, "_count"}, 32'(out_count), 32'(c));
    check({tag, "_flag"},  32'(out_flag),  32'(f));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] ovf_exp;
`ifdef FP_ACC_SAT_EN
    ovf_exp = 16'h7BFF;
`else
    ovf_exp = 16'h7C00;
`endif

    // reset state, in_ready held low while reset is high
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_flag",  32'(out_flag),  32'd0);
    aresetn = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // 1.0 + 2.0 = 3.0, with latency check on the last term
    send(16'h3C00, 1'b0);
    check("align_in_ready", 32'(in_ready), 32'd0);
    send(16'h4000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t1_early_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_lat_valid", 32'(out_valid), 32'd1);
    expect_out("t1", 16'h4200, 8'd2, 3'b000);

    send(16'h3C00, 1'b0);
    send(16'hBC00, 1'b1);
    expect_out("t2_cancel", 16'h0000, 8'd2, 3'b001);

    send(16'h3C00, 1'b0);
    send(16'h1000, 1'b1);
    expect_out("t3_halfway", 16'h3C01, 8'd2, 3'b000);

    send(16'h7BFF, 1'b0);
    send(16'h7BFF, 1'b1);
    expect_out("t4_ovf", ovf_exp, 8'd2, 3'b100);

    send(16'h0001, 1'b0);
    send(16'h0001, 1'b1);
    expect_out("t5_sub", 16'h0002, 8'd2, 3'b010);

    // -2.0 + 1.0 = -1.0
    send(16'hC000, 1'b0);
    send(16'h3C00, 1'b1);
    expect_out("neg", 16'hBC00, 8'd2, 3'b000);

    // inf + (-inf) keeps the accumulator sign
    send(16'h7C00, 1'b0);
    send(16'hFC00, 1'b1);
    expect_out("inf", 16'h7C00, 8'd2, 3'b100);

    // 4.0 + (-2.0) = 2.0, held with out_ready low
    send(16'h4400, 1'b0);
    send(16'hC000, 1'b1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid",    32'(out_valid), 32'd1);
      check("hold_data",     32'(out_data),  32'h4000);
      check("hold_in_ready", 32'(in_ready),  32'd0);
      @(negedge clk);
    end
    expect_out("hold", 16'h4000, 8'd2, 3'b000);
    send(16'h4000, 1'b1);
    expect_out("after_hold", 16'h4000, 8'd1, 3'b000);

    // reset during ADD aborts a last term
    send(16'h3C00, 1'b1);
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    check("abort_valid0",    32'(out_valid), 32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    check("abort_valid1",    32'(out_valid), 32'd0);
    aresetn = 1'b0;
    @(negedge clk);
    send(16'h4000, 1'b1);
    expect_out("after_abort", 16'h4000, 8'd1, 3'b000);

    // counter saturation over 256 zero terms
    for (int i = 0; i < 255; i++) send(16'h0000, 1'b0);
    send(16'h0000, 1'b1);
    expect_out("count_sat", 16'h0000, 8'd255, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
